// File: rtl/instr_ctrl.sv
// ----------------------------------------------------------------------------
// instr_ctrl
//   Instruction sequencer for a small accumulator-style processor. It fetches
//   one instruction per two cycles from program ROM and decodes the opcode. It
//   drives the program counter controls and the register-file write strobe.
//   The IN instruction stalls until the user presses the go switch once. The
//   HALT instruction parks the controller until reset.
//
// Parameters
//   AddrSz   program address width (matches pc)
//   InstrSz  instruction width; opcode = IR[InstrSz-1 -: 4], offset = IR[AddrSz-1:0]
//
// Ports
//   clk         in   single clock, all state on rising edge
//   n_reset     in   asynchronous active-low reset
//   instr       in   ROM data at current pc (combinational)
//   alu_zero    in   ALU zero flag for the operands of the latched IR
//   go          in   asynchronous user go switch (synchronized internally)
//   halt        out  1 = pc holds its address
//   rel_branch  out  1 = pc adds offset instead of 1
//   offset      out  two's-complement branch offset from IR
//   ir          out  latched instruction to the datapath
//   reg_we      out  one-cycle register-file write strobe
//   in_sel      out  1 = register-file write data comes from the switch input
//   done        out  1 while halted
//   illegal     out  sticky flag, set by any undefined opcode
// ----------------------------------------------------------------------------
module instr_ctrl #(
  parameter int AddrSz  = 6,
  parameter int InstrSz = 20
) (
  input  logic               clk,
  input  logic               n_reset,
  input  logic [InstrSz-1:0] instr,
  input  logic               alu_zero,
  input  logic               go,
  output logic               halt,
  output logic               rel_branch,
  output logic [AddrSz-1:0]  offset,
  output logic [InstrSz-1:0] ir,
  output logic               reg_we,
  output logic               in_sel,
  output logic               done,
  output logic               illegal
);

  localparam logic [3:0] OP_NOP  = 4'h0;
  localparam logic [3:0] OP_ADD  = 4'h1;
  localparam logic [3:0] OP_ADDI = 4'h2;
  localparam logic [3:0] OP_MULI = 4'h3;
  localparam logic [3:0] OP_BEQ  = 4'h4;
  localparam logic [3:0] OP_BNE  = 4'h5;
  localparam logic [3:0] OP_B    = 4'h6;
  localparam logic [3:0] OP_IN   = 4'h7;
  localparam logic [3:0] OP_HALT = 4'hF;

  typedef enum logic [2:0] {
    FETCH,
    EXEC,
    WAIT_GO,
    WAIT_REL,
    HALTED
  } state_t;

  state_t             state;
  state_t             next_state;
  logic [InstrSz-1:0] ir_q;
  logic               illegal_q;
  logic               go_meta;
  logic               go_sync;
  logic [3:0]         opcode;
  logic               opcode_undef;

  assign opcode  = ir_q[InstrSz-1 -: 4];
  assign ir      = ir_q;
  assign offset  = ir_q[AddrSz-1:0];
  assign illegal = illegal_q;

  always_comb begin
    opcode_undef = 1'b1;
    case (opcode)
      OP_NOP, OP_ADD, OP_ADDI, OP_MULI,
      OP_BEQ, OP_BNE, OP_B, OP_IN, OP_HALT: opcode_undef = 1'b0;
      default:                              opcode_undef = 1'b1;
    endcase
  end

  // The go switch is asynchronous to clk; only go_sync is used by the FSM.
  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      go_meta <= 1'b0;
      go_sync <= 1'b0;
    end else begin
      go_meta <= go;
      go_sync <= go_meta;
    end
  end

  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      state <= FETCH;
    end else begin
      state <= next_state;
    end
  end

  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      ir_q <= '0;
    end else if (state == FETCH) begin
      ir_q <= instr;
    end
  end

  // Sticky until reset; the undefined instruction itself still runs as a NOP.
  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      illegal_q <= 1'b0;
    end else if ((state == EXEC) && opcode_undef) begin
      illegal_q <= 1'b1;
    end
  end

  always_comb begin
    next_state = state;
    halt       = 1'b1;
    rel_branch = 1'b0;
    reg_we     = 1'b0;
    in_sel     = 1'b0;
    done       = 1'b0;

    case (state)
      FETCH: begin
        next_state = EXEC;
      end

      // pc advances exactly once here, except for IN and HALT which hold it.
      EXEC: begin
        next_state = FETCH;
        halt       = 1'b0;
        case (opcode)
          OP_ADD, OP_ADDI, OP_MULI: reg_we     = 1'b1;
          OP_BEQ:                   rel_branch = alu_zero;
          OP_BNE:                   rel_branch = ~alu_zero;
          OP_B:                     rel_branch = 1'b1;
          OP_IN: begin
            halt       = 1'b1;
            next_state = WAIT_GO;
          end
          OP_HALT: begin
            halt       = 1'b1;
            next_state = HALTED;
          end
          default: ;
        endcase
      end

      // The pc increment for IN is deferred to the cycle the input is taken.
      WAIT_GO: begin
        if (go_sync) begin
          reg_we     = 1'b1;
          in_sel     = 1'b1;
          halt       = 1'b0;
          next_state = WAIT_REL;
        end
      end

      // Waiting for release keeps one press from loading more than one input.
      WAIT_REL: begin
        if (!go_sync) begin
          next_state = FETCH;
        end
      end

      HALTED: begin
        done = 1'b1;
      end

      default: begin
        next_state = FETCH;
      end
    endcase
  end

endmodule

// File: tb/tb_instr_ctrl.sv
// ----------------------------------------------------------------------------
// tb_instr_ctrl
//   Bench for instr_ctrl. It models a program counter and a writable ROM
//   around the controller. Each time the pc advances (halt low), the monitor
//   pops the next expected event from the scoreboard queue and compares it.
//   Directed programs push their hand-computed events before they run.
// ----------------------------------------------------------------------------
module tb_instr_ctrl;

  localparam int AddrSz  = 6;
  localparam int InstrSz = 20;

  localparam logic [3:0] OP_NOP  = 4'h0;
  localparam logic [3:0] OP_ADD  = 4'h1;
  localparam logic [3:0] OP_ADDI = 4'h2;
  localparam logic [3:0] OP_MULI = 4'h3;
  localparam logic [3:0] OP_BEQ  = 4'h4;
  localparam logic [3:0] OP_BNE  = 4'h5;
  localparam logic [3:0] OP_B    = 4'h6;
  localparam logic [3:0] OP_IN   = 4'h7;
  localparam logic [3:0] OP_HALT = 4'hF;

  typedef struct packed {
    logic [3:0]        op;
    logic [AddrSz-1:0] pc;
    logic              rel;
    logic              we;
    logic              insel;
  } ev_t;

  logic               clk;
  logic               n_reset;
  logic [InstrSz-1:0] instr;
  logic               alu_zero;
  logic               go;
  logic               halt;
  logic               rel_branch;
  logic [AddrSz-1:0]  offset;
  logic [InstrSz-1:0] ir;
  logic               reg_we;
  logic               in_sel;
  logic               done;
  logic               illegal;

  logic [AddrSz-1:0]  pc;
  logic [InstrSz-1:0] rom [0:(1<<AddrSz)-1];
  ev_t                sbq [$];
  int                 checks;
  int                 errors;

  instr_ctrl #(.AddrSz(AddrSz), .InstrSz(InstrSz)) dut (
    .clk        (clk),
    .n_reset    (n_reset),
    .instr      (instr),
    .alu_zero   (alu_zero),
    .go         (go),
    .halt       (halt),
    .rel_branch (rel_branch),
    .offset     (offset),
    .ir         (ir),
    .reg_we     (reg_we),
    .in_sel     (in_sel),
    .done       (done),
    .illegal    (illegal)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Program counter and ROM that the controller steers.
  always @(posedge clk or negedge n_reset) begin
    if (!n_reset)
      pc <= '0;
    else if (!halt)
      pc <= rel_branch ? pc + offset : pc + 1'b1;
  end

  assign instr = rom[pc];

  // Monitor: every cycle the pc is allowed to move is an observable event.
  always @(negedge clk) begin
    ev_t got;
    ev_t exp;
    if (n_reset && !halt) begin
      got = '{op: ir[InstrSz-1 -: 4], pc: pc, rel: rel_branch, we: reg_we, insel: in_sel};
      checks++;
      if (sbq.size() == 0) begin
        errors++;
        $display("[TB] FAIL sb_unexpected: got op=%h pc=%0d rel=%b we=%b insel=%b, required no event",
                 got.op, got.pc, got.rel, got.we, got.insel);
      end else begin
        exp = sbq.pop_front();
        if (got !== exp) begin
          errors++;
          $display("[TB] FAIL sb_event: got op=%h pc=%0d rel=%b we=%b insel=%b, required op=%h pc=%0d rel=%b we=%b insel=%b",
                   got.op, got.pc, got.rel, got.we, got.insel,
                   exp.op, exp.pc, exp.rel, exp.we, exp.insel);
        end
      end
    end
  end

  function automatic logic [InstrSz-1:0] enc(input logic [3:0] op, input logic [AddrSz-1:0] off);
    enc = {op, 10'h155, off};
  endfunction

  function automatic ev_t mkEv(input logic [3:0] op, input int p, input logic rel,
                               input logic we, input logic insel);
    mkEv = '{op: op, pc: AddrSz'(p), rel: rel, we: we, insel: insel};
  endfunction

  task automatic applyStimulus(input logic rst_v, input logic go_v, input logic az_v);
    n_reset  = rst_v;
    go       = go_v;
    alu_zero = az_v;
  endtask

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h, required %0h", name, act, exp);
    end
  endtask

  task automatic clearRom();
    for (int i = 0; i < (1 << AddrSz); i++) rom[i] = enc(OP_HALT, '0);
  endtask

  // Hold reset across two edges, then release at a falling edge so the next
  // rising edge is the first fetch from address 0.
  task automatic doReset(input logic az);
    @(negedge clk);
    applyStimulus(1'b0, 1'b0, az);
    sbq.delete();
    @(negedge clk);
    @(negedge clk);
    applyStimulus(1'b1, 1'b0, az);
  endtask

  task automatic waitDrain(input string name, input int limit);
    int n = 0;
    while (sbq.size() != 0 && n < limit) begin
      @(posedge clk); #1;
      n++;
    end
    checks++;
    if (sbq.size() != 0) begin
      errors++;
      $display("[TB] FAIL %s: got %0d events still pending, required 0", name, sbq.size());
    end
  endtask

  task automatic waitDone(input string name, input int limit);
    int n = 0;
    while (done !== 1'b1 && n < limit) begin
      @(posedge clk); #1;
      n++;
    end
    checkOutput(name, 32'(done), 32'd1);
  endtask

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog: got no finish, required finish within time limit");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    checks = 0;
    errors = 0;
    clearRom();
    applyStimulus(1'b1, 1'b0, 1'b0);
    #2;
    n_reset = 1'b0;
    #1;
    checkOutput("rst_halt",    32'(halt),       32'd1);
    checkOutput("rst_rel",     32'(rel_branch), 32'd0);
    checkOutput("rst_we",      32'(reg_we),     32'd0);
    checkOutput("rst_insel",   32'(in_sel),     32'd0);
    checkOutput("rst_done",    32'(done),       32'd0);
    checkOutput("rst_illegal", 32'(illegal),    32'd0);
    checkOutput("rst_offset",  32'(offset),     32'd0);
    checkOutput("rst_ir",      32'(ir),         32'd0);

    // ADDI then NOP: two cycles each, write strobe only in the ADDI EXEC.
    $display("[TB] test addi_nop");
    clearRom();
    rom[0] = enc(OP_ADDI, 6'h05);
    rom[1] = enc(OP_NOP,  6'h00);
    doReset(1'b0);
    sbq.push_back(mkEv(OP_ADDI, 0, 1'b0, 1'b1, 1'b0));
    sbq.push_back(mkEv(OP_NOP,  1, 1'b0, 1'b0, 1'b0));
    @(posedge clk); #1;
    checkOutput("c1_we",   32'(reg_we), 32'd1);
    checkOutput("c1_halt", 32'(halt),   32'd0);
    checkOutput("c1_ir",   32'(ir),     32'(enc(OP_ADDI, 6'h05)));
    @(posedge clk); #1;
    checkOutput("c2_we",   32'(reg_we), 32'd0);
    checkOutput("c2_halt", 32'(halt),   32'd1);
    checkOutput("c2_pc",   32'(pc),     32'd1);
    @(posedge clk); #1;
    checkOutput("c3_we",   32'(reg_we), 32'd0);
    @(posedge clk); #1;
    checkOutput("c4_pc",   32'(pc),     32'd2);
    waitDrain("addi_drain", 4);

    // BEQ -4 at address 5, taken and not taken.
    for (int t = 0; t < 2; t++) begin
      logic az;
      az = (t == 0);
      $display("[TB] test beq alu_zero=%0b", az);
      clearRom();
      for (int i = 0; i < 5; i++) rom[i] = enc(OP_NOP, 6'h00);
      rom[5] = enc(OP_BEQ, 6'h3C);
      doReset(az);
      for (int i = 0; i < 5; i++) sbq.push_back(mkEv(OP_NOP, i, 1'b0, 1'b0, 1'b0));
      sbq.push_back(mkEv(OP_BEQ, 5, az, 1'b0, 1'b0));
      waitDrain("beq_drain", 30);
      checkOutput(az ? "beq_taken_pc" : "beq_fall_pc", 32'(pc), az ? 32'd1 : 32'd6);
    end

    // BNE taken, then two unconditional branches ending on HALT at 1.
    $display("[TB] test bne_b");
    clearRom();
    rom[0] = enc(OP_BNE, 6'h02);
    rom[2] = enc(OP_B,   6'h02);
    rom[4] = enc(OP_B,   6'h3D);
    doReset(1'b0);
    sbq.push_back(mkEv(OP_BNE, 0, 1'b1, 1'b0, 1'b0));
    sbq.push_back(mkEv(OP_B,   2, 1'b1, 1'b0, 1'b0));
    sbq.push_back(mkEv(OP_B,   4, 1'b1, 1'b0, 1'b0));
    waitDone("bne_b_done", 30);
    checkOutput("bne_b_pc", 32'(pc), 32'd1);
    waitDrain("bne_b_drain", 2);

    // IN at address 2: single input load per go press.
    $display("[TB] test in_go");
    clearRom();
    rom[0] = enc(OP_NOP, 6'h00);
    rom[1] = enc(OP_NOP, 6'h00);
    rom[2] = enc(OP_IN,  6'h00);
    doReset(1'b0);
    sbq.push_back(mkEv(OP_NOP, 0, 1'b0, 1'b0, 1'b0));
    sbq.push_back(mkEv(OP_NOP, 1, 1'b0, 1'b0, 1'b0));
    sbq.push_back(mkEv(OP_IN,  2, 1'b0, 1'b1, 1'b1));
    repeat (10) begin @(posedge clk); #1; end
    checkOutput("in_wait_halt",    32'(halt),       32'd1);
    checkOutput("in_wait_pc",      32'(pc),         32'd2);
    checkOutput("in_wait_pending", 32'(sbq.size()), 32'd1);
    go = 1'b1;
    @(posedge clk); #1;
    checkOutput("in_go1_we", 32'(reg_we), 32'd0);
    @(posedge clk); #1;
    checkOutput("in_go2_we",    32'(reg_we), 32'd1);
    checkOutput("in_go2_insel", 32'(in_sel), 32'd1);
    repeat (3) begin @(posedge clk); #1; end
    checkOutput("in_rel_halt", 32'(halt),   32'd1);
    checkOutput("in_rel_pc",   32'(pc),     32'd3);
    checkOutput("in_rel_done", 32'(done),   32'd0);
    checkOutput("in_rel_we",   32'(reg_we), 32'd0);
    go = 1'b0;
    waitDone("in_after_done", 20);
    checkOutput("in_after_pc", 32'(pc), 32'd3);
    waitDrain("in_drain", 2);

    // HALT at address 4 stays put until reset.
    $display("[TB] test halt");
    clearRom();
    for (int i = 0; i < 4; i++) rom[i] = enc(OP_NOP, 6'h00);
    doReset(1'b0);
    for (int i = 0; i < 4; i++) sbq.push_back(mkEv(OP_NOP, i, 1'b0, 1'b0, 1'b0));
    waitDone("halt_done", 30);
    repeat (20) begin @(posedge clk); #1; end
    checkOutput("halt_hold_done", 32'(done), 32'd1);
    checkOutput("halt_hold_halt", 32'(halt), 32'd1);
    checkOutput("halt_hold_pc",   32'(pc),   32'd4);
    n_reset = 1'b0;
    #1;
    checkOutput("halt_rst_done", 32'(done), 32'd0);
    checkOutput("halt_rst_pc",   32'(pc),   32'd0);
    waitDrain("halt_drain", 2);

    // Undefined opcode 0xA runs as NOP and leaves illegal set.
    $display("[TB] test illegal");
    clearRom();
    rom[0] = enc(OP_NOP,  6'h00);
    rom[1] = enc(4'hA,    6'h07);
    rom[2] = enc(OP_ADD,  6'h00);
    rom[3] = enc(OP_MULI, 6'h03);
    doReset(1'b0);
    checkOutput("ill_before", 32'(illegal), 32'd0);
    sbq.push_back(mkEv(OP_NOP,  0, 1'b0, 1'b0, 1'b0));
    sbq.push_back(mkEv(4'hA,    1, 1'b0, 1'b0, 1'b0));
    sbq.push_back(mkEv(OP_ADD,  2, 1'b0, 1'b1, 1'b0));
    sbq.push_back(mkEv(OP_MULI, 3, 1'b0, 1'b1, 1'b0));
    waitDone("ill_done", 30);
    checkOutput("ill_sticky", 32'(illegal), 32'd1);
    checkOutput("ill_pc",     32'(pc),      32'd4);
    waitDrain("ill_drain", 2);

    // Reset during ADD EXEC kills the write strobe immediately.
    $display("[TB] test reset_mid_exec");
    clearRom();
    rom[0] = enc(OP_ADD, 6'h15);
    doReset(1'b0);
    @(posedge clk); #1;
    checkOutput("mid_pre_we",     32'(reg_we), 32'd1);
    checkOutput("mid_pre_offset", 32'(offset), 32'h15);
    n_reset = 1'b0;
    #1;
    checkOutput("mid_we",     32'(reg_we),     32'd0);
    checkOutput("mid_halt",   32'(halt),       32'd1);
    checkOutput("mid_rel",    32'(rel_branch), 32'd0);
    checkOutput("mid_insel",  32'(in_sel),     32'd0);
    checkOutput("mid_done",   32'(done),       32'd0);
    checkOutput("mid_offset", 32'(offset),     32'd0);
    checkOutput("mid_ir",     32'(ir),         32'd0);
    repeat (2) @(negedge clk);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
